// File: rtl/alu_operand_fetch_if.sv
// Handshake and writeback bundle between decode, the operand-fetch stage and alu_add.
interface alu_operand_fetch_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [AW-1:0]   rd_addr_in;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [AW-1:0]   rd_addr_out;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rd_addr_in, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, rs1, rs2, rd_addr_out
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rd_addr_in, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, rs1, rs2, rd_addr_out
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: register file, same-cycle writeback bypass and a one-entry
// valid/ready output register feeding alu_add.
module alu_operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_fetch_if.slave bus
);

  logic [XLEN-1:0] regs_q [NREG];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   idx1_q, idx1_d;
  logic [AW-1:0]   idx2_q, idx2_d;

  logic in_ready_c;
  logic accept_c;
  logic transfer_c;
  logic wb_hit_c;

  // Only in-range, non-zero writebacks are architecturally visible.
  assign wb_hit_c   = bus.wb_en && (bus.wb_addr != '0) && (32'(bus.wb_addr) < NREG);
  assign in_ready_c = !out_valid_q || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign transfer_c = out_valid_q && bus.out_ready;

  function automatic logic [XLEN-1:0] read_op(input logic [AW-1:0] addr);
    if ((addr == '0) || (32'(addr) >= NREG)) begin
      return '0;
    end else if (wb_hit_c && (bus.wb_addr == addr)) begin
      return bus.wb_data;
    end else begin
      return regs_q[addr];
    end
  endfunction

  // Register file; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wb_hit_c) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output register next state: load on accept, drop on transfer, else hold with
  // stall coherence so a held operand tracks writebacks to its source.
  always_comb begin
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      rs1_d       = read_op(bus.rs1_addr);
      rs2_d       = read_op(bus.rs2_addr);
      rd_d        = bus.rd_addr_in;
      idx1_d      = bus.rs1_addr;
      idx2_d      = bus.rs2_addr;
    end else if (transfer_c) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && wb_hit_c) begin
      if (bus.wb_addr == idx1_q) rs1_d = bus.wb_data;
      if (bus.wb_addr == idx2_q) rs2_d = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd_addr_out = rd_q;

endmodule
